uart_baud_gen: RTL and testbench
================================

// Module: uart_baud_gen
// PURPOSE
//   Parametrised UART baud-tick generator. Single 50 MHz domain, NCO (phase-accumulator) based.
//   Run-time baud select from an 8-entry table.
//   Outputs:
//     - an oversample tick for the RX sampler
//     - a mid-bit tick for the RX sampler
//     - a 1x tick for the TX shifter
//     - a 50% baud-rate square wave
//   Sits between the board clock and the uart_tx/uart_rx engines.
// PARAMETERS
//   CLK_FREQ    50_000_000  input clock frequency, Hz
//   OVERSAMPLE  16          os_tick per bit; power of 2, 4..64
//   ACC_W       24          NCO accumulator width, bits; 16..32
// PORTS
//   clk_50m      in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   en           in   1  1 = generator running; 0 = held idle, baud_sel loadable
//   baud_sel     in   3  0..7 = 9600,19200,38400,57600,115200,230400,460800,921600
//   rx_restart   in   1  1-cycle pulse on RX start-bit edge; realigns phase
//   os_tick      out  1  1-cycle pulse at BAUD*OVERSAMPLE
//   rx_mid_tick  out  1  1-cycle pulse at mid-bit (os_cnt == OVERSAMPLE/2-1)
//   tx_tick      out  1  1-cycle pulse at BAUD (os_cnt == OVERSAMPLE-1)
//   baud_clk     out  1  square wave at BAUD; 0 when idle
// BEHAVIOUR
//   Increment table (elaboration time, 64-bit math):
//     INC[i] = (BAUD[i]*OVERSAMPLE*2^ACC_W + CLK_FREQ/2) / CLK_FREQ
//     Elaboration error if any BAUD*OVERSAMPLE >= CLK_FREQ.
//   Registers: acc[ACC_W-1:0], os_cnt[log2(OVERSAMPLE)-1:0], inc_r[ACC_W-1:0], all outputs.
//   Reset (async, rst_n=0):
//     acc=0, os_cnt=0, inc_r=INC[4] (115200), all outputs 0.
//     Takes effect immediately, not at the next edge.
//   en=0:
//     acc=0, os_cnt=0, outputs 0.
//     inc_r <= INC[baud_sel] every cycle.
//   en=1:
//     inc_r frozen; baud_sel changes are ignored until en has been low for >=1 cycle.
//   Each edge with en=1 and rx_restart=0:
//     {c,acc} <= acc + inc_r (ACC_W+1-bit add); os_tick <= c.
//     If c: os_cnt <= os_cnt+1, wraps OVERSAMPLE-1 -> 0.
//       rx_mid_tick <= (os_cnt == OVERSAMPLE/2-1)
//       tx_tick     <= (os_cnt == OVERSAMPLE-1)
//     Else: rx_mid_tick=0, tx_tick=0.
//   Tick timing:
//     Ticks are registered; each is high for exactly one cycle.
//     tx_tick and rx_mid_tick are only ever high in the same cycle as os_tick.
//     tx_tick and rx_mid_tick are never high together.
//   baud_clk <= en & (os_cnt_next >= OVERSAMPLE/2).
//   rx_restart=1 with en=1:
//     acc<=0, os_cnt<=0, all tick outputs <=0.
//     Overrides a carry in the same cycle; that tick is dropped.
//   First ticks after restart (or after en rises):
//     first os_tick on edge N = ceil(2^ACC_W/inc_r) after the edge that sampled
//     the restart or the en rise (N=28 at 115200/16/24b);
//     rx_mid_tick on the (OVERSAMPLE/2)th os_tick;
//     tx_tick on the OVERSAMPLE-th os_tick.
//   rx_restart with en=0: no effect.
//   Long-term tick rate exact to INC rounding: <1 ppm at defaults.
//   os_tick spacing jitter is at most 1 cycle.
// TESTING
//   1. en=1, sel=4, 1_000_000 cycles -> 36864+-1 os_tick, 2304+-1 tx_tick; tx spacing 434/435 cycles.
//   2. en=1, sel=0 -> os_tick spacing 325/326 cycles, tx_tick spacing 5208/5209, rx_mid 8 os_ticks after tx_tick.
//   3. sel=4, rx_restart mid-bit -> os_tick on edge 28; rx_mid_tick on 8th os_tick; tx_tick on 16th.
//   4. rx_restart on the cycle a carry is due -> no os_tick that cycle; next per scenario 3.
//   5. en=1, sel 4->7 -> rate unchanged; en=0 one cycle then en=1 -> os_tick spacing 3/4 cycles.
//   6. rst_n low between edges mid-run -> all outputs 0 immediately; after release, inc_r=INC[4].

Source files
------------

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: NCO-based UART baud tick generator for a single clock domain.
// A phase accumulator adds a per-baud increment every enabled cycle. Its carry
// is the oversample tick. A small counter of those ticks produces the mid-bit
// tick, the 1x tick and a 50% duty baud-rate square wave.
// Ports:
//   clk_50m     - system clock
//   rst_n       - asynchronous active-low reset
//   en          - 1 = running; 0 = held idle, increment reloaded from baud_sel
//   baud_sel    - 0..7 = 9600,19200,38400,57600,115200,230400,460800,921600
//   rx_restart  - 1-cycle pulse on RX start-bit edge, realigns phase
//   os_tick     - 1-cycle pulse at BAUD*OVERSAMPLE
//   rx_mid_tick - 1-cycle pulse at mid-bit
//   tx_tick     - 1-cycle pulse at BAUD
//   baud_clk    - square wave at BAUD, 0 when idle
module uart_baud_gen #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 24
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] baud_sel,
    input  logic       rx_restart,
    output logic       os_tick,
    output logic       rx_mid_tick,
    output logic       tx_tick,
    output logic       baud_clk
);

    localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
    localparam int unsigned N_BAUD = 8;

    // Supported baud rates, indexed by baud_sel.
    function automatic longint unsigned baud_rate(input int unsigned idx);
        case (idx)
            0:       return 64'd9600;
            1:       return 64'd19200;
            2:       return 64'd38400;
            3:       return 64'd57600;
            4:       return 64'd115200;
            5:       return 64'd230400;
            6:       return 64'd460800;
            default: return 64'd921600;
        endcase
    endfunction

    // Rounded phase increment for one baud rate.
    function automatic logic [ACC_W-1:0] calc_inc(input int unsigned idx);
        longint unsigned num;
        num = baud_rate(idx) * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_FREQ / 2);
        return ACC_W'(num / 64'(CLK_FREQ));
    endfunction

    localparam logic [ACC_W-1:0] INC_TAB [N_BAUD] = '{
        calc_inc(0), calc_inc(1), calc_inc(2), calc_inc(3),
        calc_inc(4), calc_inc(5), calc_inc(6), calc_inc(7)
    };

    // Reject parameter sets the generator cannot honour.
    generate
        if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
            $error("uart_baud_gen: OVERSAMPLE must be a power of 2 in 4..64");
        end
        if (ACC_W < 16 || ACC_W > 32) begin : g_bad_acc
            $error("uart_baud_gen: ACC_W must be in 16..32");
        end
        for (genvar gi = 0; gi < N_BAUD; gi++) begin : g_chk_baud
            if (baud_rate(gi) * 64'(OVERSAMPLE) >= 64'(CLK_FREQ)) begin : g_bad_rate
                $error("uart_baud_gen: BAUD*OVERSAMPLE must be below CLK_FREQ");
            end
        end
    endgenerate

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [OS_W-1:0]  r_os_cnt;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_os_wrap;
    logic             w_os_mid;
    logic [OS_W-1:0]  w_os_cnt_next;
    logic             w_baud_clk_next;

    // Accumulator add; the extra MSB is the oversample carry.
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry   = w_sum[ACC_W];
    assign w_os_wrap = (r_os_cnt == OS_W'(OVERSAMPLE - 1));
    assign w_os_mid  = (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));

    // Next oversample count; idle and restart both force phase zero.
    always_comb begin
        w_os_cnt_next = r_os_cnt;
        if (!en || rx_restart) begin
            w_os_cnt_next = '0;
        end else if (w_carry) begin
            w_os_cnt_next = w_os_wrap ? '0 : r_os_cnt + OS_W'(1);
        end
    end

    // Square wave is high for the upper half of the oversample count.
    assign w_baud_clk_next = en & (w_os_cnt_next >= OS_W'(OVERSAMPLE / 2));

    // Phase accumulator, oversample counter, increment register and ticks.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_os_cnt    <= '0;
            r_inc       <= INC_TAB[4];
            os_tick     <= 1'b0;
            rx_mid_tick <= 1'b0;
            tx_tick     <= 1'b0;
            baud_clk    <= 1'b0;
        end else begin
            r_os_cnt <= w_os_cnt_next;
            baud_clk <= w_baud_clk_next;
            if (!en) begin
                // Idle: the increment tracks baud_sel so it is ready when en rises.
                r_acc       <= '0;
                r_inc       <= INC_TAB[baud_sel];
                os_tick     <= 1'b0;
                rx_mid_tick <= 1'b0;
                tx_tick     <= 1'b0;
            end else if (rx_restart) begin
                // Restart wins over a coincident carry; that tick is dropped.
                r_acc       <= '0;
                os_tick     <= 1'b0;
                rx_mid_tick <= 1'b0;
                tx_tick     <= 1'b0;
            end else begin
                r_acc       <= w_sum[ACC_W-1:0];
                os_tick     <= w_carry;
                rx_mid_tick <= w_carry & w_os_mid;
                tx_tick     <= w_carry & w_os_wrap;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen: directed scenarios plus a random phase. The
// reference model predicts every output from a closed-form count of phase
// wraps, floor(k*inc / 2^ACC_W), where k counts accumulating edges since the
// last phase origin (reset, idle cycle or restart).
module tb_uart_baud_gen;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned ACC_W    = 24;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] baud_sel;
    logic       rx_restart;
    logic       os_tick;
    logic       rx_mid_tick;
    logic       tx_tick;
    logic       baud_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    longint unsigned m_inc;
    longint unsigned m_k;
    logic e_os, e_mid, e_tx, e_bclk;

    // Observed-event history for spacing checks.
    int   cyc = 0;
    int   last_os = -1, last_tx = -1, os_since_tx = -1;
    int   os_gap, tx_gap, mid_dist;
    logic got_os, got_mid, got_tx;
    int   n_os, n_tx;
    logic rnd_en;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .OVERSAMPLE(OS),
        .ACC_W     (ACC_W)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .en         (en),
        .baud_sel   (baud_sel),
        .rx_restart (rx_restart),
        .os_tick    (os_tick),
        .rx_mid_tick(rx_mid_tick),
        .tx_tick    (tx_tick),
        .baud_clk   (baud_clk)
    );

    always #10 clk_50m = ~clk_50m;

    function automatic longint unsigned ref_inc(input int unsigned s);
        longint unsigned baud;
        case (s)
            0:       baud = 9600;
            1:       baud = 19200;
            2:       baud = 38400;
            3:       baud = 57600;
            4:       baud = 115200;
            5:       baud = 230400;
            6:       baud = 460800;
            default: baud = 921600;
        endcase
        return (baud * OS * (64'd1 << ACC_W) + CLK_FREQ / 2) / CLK_FREQ;
    endfunction

    // Number of phase wraps after k accumulating edges.
    function automatic longint unsigned wraps(input longint unsigned k);
        return (k * m_inc) >> ACC_W;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clear_hist();
        last_os = -1;
        last_tx = -1;
        os_since_tx = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_os_tick"}, 64'(os_tick), 64'd0);
        chk({tag, "_rx_mid_tick"}, 64'(rx_mid_tick), 64'd0);
        chk({tag, "_tx_tick"}, 64'(tx_tick), 64'd0);
        chk({tag, "_baud_clk"}, 64'(baud_clk), 64'd0);
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic e, input logic [2:0] s, input logic r);
        longint unsigned c_now, c_prev;
        @(negedge clk_50m);
        en = e;
        baud_sel = s;
        rx_restart = r;
        @(posedge clk_50m);
        cyc++;
        e_os = 1'b0; e_mid = 1'b0; e_tx = 1'b0; e_bclk = 1'b0;
        if (!e) begin
            m_k = 0;
            m_inc = ref_inc(int'(s));
        end else if (r) begin
            m_k = 0;
        end else begin
            m_k++;
            c_now  = wraps(m_k);
            c_prev = wraps(m_k - 1);
            e_os   = (c_now != c_prev);
            e_mid  = e_os && ((c_prev % OS) == OS / 2 - 1);
            e_tx   = e_os && ((c_prev % OS) == OS - 1);
            e_bclk = (c_now % OS) >= OS / 2;
        end
        #1;
        chk("os_tick", 64'(os_tick), 64'(e_os));
        chk("rx_mid_tick", 64'(rx_mid_tick), 64'(e_mid));
        chk("tx_tick", 64'(tx_tick), 64'(e_tx));
        chk("baud_clk", 64'(baud_clk), 64'(e_bclk));
        got_os = os_tick; got_mid = rx_mid_tick; got_tx = tx_tick;
        os_gap = 0; tx_gap = 0; mid_dist = -1;
        if (!e || r) begin
            clear_hist();
        end else begin
            if (os_tick === 1'b1) begin
                if (last_os >= 0) os_gap = cyc - last_os;
                last_os = cyc;
                if (os_since_tx >= 0) os_since_tx++;
            end
            if (rx_mid_tick === 1'b1) mid_dist = os_since_tx;
            if (tx_tick === 1'b1) begin
                if (last_tx >= 0) tx_gap = cyc - last_tx;
                last_tx = cyc;
                os_since_tx = 0;
            end
        end
    endtask

    // After a phase origin at 115200: first os_tick on edge 28, mid on 8th, tx on 16th.
    task automatic first_ticks(input string tag);
        int n_os_l;
        logic seen_tx;
        n_os_l = 0;
        seen_tx = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            step(1'b1, 3'd4, 1'b0);
            if (got_os === 1'b1) begin
                n_os_l++;
                if (n_os_l == 1) chk({tag, "_first_os_edge"}, 64'(i), 64'd28);
            end
            if (got_mid === 1'b1) chk({tag, "_mid_os_index"}, 64'(n_os_l), 64'd8);
            if (got_tx === 1'b1) begin
                chk({tag, "_tx_os_index"}, 64'(n_os_l), 64'd16);
                seen_tx = 1'b1;
                break;
            end
        end
        chk({tag, "_tx_seen"}, 64'(seen_tx), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        baud_sel = 3'd4;
        rx_restart = 1'b0;
        m_inc = ref_inc(4);
        m_k = 0;

        // Reset state.
        repeat (2) @(posedge clk_50m);
        #1;
        chk_all_zero("reset");
        @(negedge clk_50m);
        rst_n = 1'b1;

        // Idle, then run and restart mid-bit.
        repeat (3) step(1'b0, 3'd4, 1'b0);
        repeat (200) step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd4, 1'b1);
        first_ticks("restart_mid");

        // Restart on the very edge a carry is due.
        for (int i = 0; i < 40; i++) begin
            if (wraps(m_k + 1) != wraps(m_k)) break;
            step(1'b1, 3'd4, 1'b0);
        end
        step(1'b1, 3'd4, 1'b1);
        chk("restart_drop_os", 64'(got_os), 64'd0);
        first_ticks("restart_carry");

        // Long run at 115200.
        step(1'b1, 3'd4, 1'b1);
        n_os = 0; n_tx = 0;
        for (int i = 0; i < 30000; i++) begin
            step(1'b1, 3'd4, 1'b0);
            if (got_os === 1'b1) n_os++;
            if (got_tx === 1'b1) n_tx++;
            if (os_gap > 0) chk_rng("os_gap_115200", os_gap, 27, 28);
            if (tx_gap > 0) chk_rng("tx_gap_115200", tx_gap, 434, 435);
        end
        chk_rng("os_count_115200", n_os, 1105, 1106);
        chk_rng("tx_count_115200", n_tx, 69, 70);

        // 9600 baud.
        step(1'b0, 3'd0, 1'b0);
        n_tx = 0;
        for (int i = 0; i < 16000; i++) begin
            step(1'b1, 3'd0, 1'b0);
            if (got_tx === 1'b1) n_tx++;
            if (os_gap > 0) chk_rng("os_gap_9600", os_gap, 325, 326);
            if (tx_gap > 0) chk_rng("tx_gap_9600", tx_gap, 5208, 5209);
            if (mid_dist >= 0) chk("mid_after_tx_9600", 64'(mid_dist), 64'd8);
        end
        chk("tx_count_9600", 64'(n_tx), 64'd3);

        // baud_sel is ignored while running; one idle cycle loads it.
        step(1'b0, 3'd4, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 3'd7, 1'b0);
            if (os_gap > 0) chk_rng("os_gap_frozen_sel", os_gap, 27, 28);
        end
        step(1'b0, 3'd7, 1'b0);
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 3'd7, 1'b0);
            if (os_gap > 0) chk_rng("os_gap_921600", os_gap, 3, 4);
        end

        // Random enables, selects and restarts.
        rnd_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) rnd_en = ~rnd_en;
            step(rnd_en, 3'($urandom_range(7)), $urandom_range(49) == 0);
        end

        // Asynchronous reset between edges while the square wave is high.
        step(1'b0, 3'd7, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 3'd7, 1'b0);
            if (e_bclk) break;
        end
        chk("pre_reset_baud_clk", 64'(baud_clk), 64'd1);
        #4;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        m_k = 0;
        m_inc = ref_inc(4);
        clear_hist();
        @(posedge clk_50m);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'd7, 1'b0);
            if (os_gap > 0) chk_rng("os_gap_after_reset", os_gap, 27, 28);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
